// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile -- two-read / one-write integer register file for the fib core.
//
// Sits directly upstream of the ALU.  Read addresses are sampled on a rising
// edge with rd_req high; the operands appear on src0/src1 after that edge and
// are held stable (with src_valid low) on every edge without a request, so
// the ALU always sees a full cycle of settled inputs.  Register x0 is not
// stored: it reads as zero and silently drops writes.
//
// Compile-time option:
//   REGFILE_BYPASS_EN  defined   -> write-first: a read that collides with a
//                                   write to the same nonzero register on the
//                                   same edge captures the new data (wd).
//                      undefined -> read-first: the read captures the value
//                                   stored before that write.
//
// Parameters:
//   XLEN       data width of every register and data port
//   NREG       number of architectural registers (x0..x{NREG-1})
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset; clears registers and outputs
//   rd_req     read request; ra0/ra1 sampled on this edge
//   ra0, ra1   read addresses for operand 0 / operand 1
//   src0, src1 registered operands to the ALU
//   src_valid  src0/src1 were captured for a request on the previous edge
//   we         write enable
//   wa         write address
//   wd         write data (ALU result or load data)
// ---------------------------------------------------------------------------
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    // Derived; not intended to be overridden.
    parameter int AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    // Read side
    input  logic            rd_req,
    input  logic [AW-1:0]   ra0,
    input  logic [AW-1:0]   ra1,
    output logic [XLEN-1:0] src0,
    output logic [XLEN-1:0] src1,
    output logic            src_valid,
    // Write side
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [XLEN-1:0] wd
);

    localparam int NPORT = 2;

    // -----------------------------------------------------------------------
    // Storage.  Only x1..x{NREG-1} exist; x0 is synthesised away entirely.
    // Flops rather than a RAM: the whole file must clear asynchronously.
    // -----------------------------------------------------------------------
    logic [XLEN-1:0] regs_reg [1:NREG-1];

    // One-hot write decode.  Only in-range nonzero addresses can match, so
    // writes to x0 and to addresses >= NREG fall through with no effect.
    logic [NREG-1:1] wr_hit;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            assign wr_hit[gi] = we && (wa == AW'(gi));

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    regs_reg[gi] <= '0;
                end else if (wr_hit[gi]) begin
                    regs_reg[gi] <= wd;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read ports.  Both ports are identical and independent; they are built
    // from one generate body over a small address/value array.
    // -----------------------------------------------------------------------
    logic [AW-1:0]   rd_addr  [NPORT];
    logic [XLEN-1:0] rd_value [NPORT];
    logic [XLEN-1:0] src_reg  [NPORT];
    logic            src_valid_reg;

    assign rd_addr[0] = ra0;
    assign rd_addr[1] = ra1;

    generate
        for (gi = 0; gi < NPORT; gi++) begin : g_port
            logic [XLEN-1:0] stored_value;

            // Stored-value mux.  Starts at zero so x0 and any out-of-range
            // address read as zero without a separate range check.
            always_comb begin
                stored_value = '0;
                for (int i = 1; i < NREG; i++) begin
                    if (rd_addr[gi] == AW'(i)) begin
                        stored_value = regs_reg[i];
                    end
                end
            end

`ifdef REGFILE_BYPASS_EN
            // A collision needs a real write landing this edge; |wr_hit is
            // already false for x0 and out-of-range addresses, so a read of
            // x0 during a write to x0 still returns zero.
            logic collide;
            assign collide      = (|wr_hit) && (wa == rd_addr[gi]);
            assign rd_value[gi] = collide ? wd : stored_value;
`else
            // Read-first: the pre-write contents are captured; the write
            // becomes visible to a request on the following edge.
            assign rd_value[gi] = stored_value;
`endif
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Operand registers.  Data only moves on a request so the ALU inputs stay
    // put between requests; src_valid simply tracks the previous rd_req.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg[0]    <= '0;
            src_reg[1]    <= '0;
            src_valid_reg <= 1'b0;
        end else begin
            src_valid_reg <= rd_req;
            if (rd_req) begin
                src_reg[0] <= rd_value[0];
                src_reg[1] <= rd_value[1];
            end
        end
    end

    assign src0      = src_reg[0];
    assign src1      = src_reg[1];
    assign src_valid = src_valid_reg;

endmodule
